hpdcache_1hot_to_binary_pipe: RTL and testbench

Registered, multi-channel one-hot to binary encoder with a valid/ready handshake and a built-in encoding-error monitor. It accepts NCH independent N-bit vectors per beat, encodes each to a Log2N-bit index with a selectable multi-hot resolution policy, and flags multi-hot violations per channel. It sits between the way-hit/victim-select logic and the downstream request pipeline of the cache controller. It replaces ad-hoc combinational encoders on timing-critical paths with a registered, backpressure-aware stage.

---
 rtl/hpdcache_1hot_to_binary_pipe.sv | 127 ++++++++++++
 tb/tb_hpdcache_1hot_to_binary_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_1hot_to_binary_pipe.sv
// Registered multi-channel one-hot to binary encoder with multi-hot detection and a saturating error-beat counter.
// Latency 1 cycle; two-entry output/skid buffer keeps ready_o registered, so upstream sees backpressure one cycle late.
module hpdcache_1hot_to_binary_pipe #(
    parameter int unsigned N         = 8,
    parameter int unsigned NCH       = 1,
    parameter int unsigned MODE      = 0,
    parameter int unsigned ERR_CNT_W = 8,
    localparam int unsigned LOG2N    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [NCH*N-1:0]       val_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [NCH*LOG2N-1:0]   idx_o,
    output logic [NCH-1:0]         hit_o,
    output logic [NCH-1:0]         err_o,
    output logic [ERR_CNT_W-1:0]   err_cnt_o,
    input  logic                   clr_err_i
);

    typedef struct packed {
        logic [NCH*LOG2N-1:0] idx;
        logic [NCH-1:0]       hit;
        logic [NCH-1:0]       err;
    } ent_t;

    // Encoding of state bits is {OUT.v, SKD.v}; 2'b01 never occurs.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t               state_q, state_d;
    ent_t                 out_q, out_d;
    ent_t                 skd_q, skd_d;
    ent_t                 enc;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 accept;
    logic                 consume;

    // Scan order makes the last set bit visited win: ascending for MODE 0, descending for MODE 1.
    always_comb begin
        enc = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            for (int i = 0; i < int'(N); i++) begin
                int b;
                b = (MODE == 0) ? i : (int'(N) - 1 - i);
                if (val_i[c*int'(N) + b]) begin
                    if (enc.hit[c]) begin
                        enc.err[c] = 1'b1;
                    end
                    enc.hit[c] = 1'b1;
                    enc.idx[c*int'(LOG2N) +: LOG2N] = LOG2N'(b);
                end
            end
        end
    end

    assign accept  = valid_i && ready_o;
    assign consume = valid_o && ready_i;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skd_d   = skd_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_d   = enc;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    out_d = enc;
                end else if (accept) begin
                    skd_d   = enc;
                    state_d = FULL;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    out_d   = skd_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_err_i) begin
            cnt_d = '0;
        end else if (accept && (|enc.err) && (cnt_q != {ERR_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skd_q   <= skd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_o   = ~state_q[0];
    assign valid_o   = state_q[1];
    assign idx_o     = out_q.idx;
    assign hit_o     = out_q.hit;
    assign err_o     = out_q.err;
    assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_hpdcache_1hot_to_binary_pipe.sv
// Bench for hpdcache_1hot_to_binary_pipe: scoreboarded single-channel instance plus MODE 1 and 4-channel instances.
module tb_hpdcache_1hot_to_binary_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: N=8, NCH=1, MODE 0, 2-bit counter
    logic       a_vld, a_rdyo, a_ovld, a_rdyi, a_clr;
    logic [7:0] a_val;
    logic [2:0] a_idx;
    logic       a_hit, a_err;
    logic [1:0] a_cnt;

    // Instance B: N=8, NCH=1, MODE 1
    logic       b_vld, b_rdyo, b_ovld;
    logic [7:0] b_val;
    logic [2:0] b_idx;
    logic       b_hit, b_err;
    logic [7:0] b_cnt;

    // Instance C: N=4, NCH=4, MODE 0
    logic        c_vld, c_rdyo, c_ovld;
    logic [15:0] c_val;
    logic [7:0]  c_idx;
    logic [3:0]  c_hit, c_err;
    logic [7:0]  c_cnt;

    hpdcache_1hot_to_binary_pipe #(.N(8), .NCH(1), .MODE(0), .ERR_CNT_W(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(a_vld), .ready_o(a_rdyo), .val_i(a_val),
        .valid_o(a_ovld), .ready_i(a_rdyi), .idx_o(a_idx), .hit_o(a_hit), .err_o(a_err),
        .err_cnt_o(a_cnt), .clr_err_i(a_clr)
    );

    hpdcache_1hot_to_binary_pipe #(.N(8), .NCH(1), .MODE(1), .ERR_CNT_W(8)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(b_vld), .ready_o(b_rdyo), .val_i(b_val),
        .valid_o(b_ovld), .ready_i(1'b1), .idx_o(b_idx), .hit_o(b_hit), .err_o(b_err),
        .err_cnt_o(b_cnt), .clr_err_i(1'b0)
    );

    hpdcache_1hot_to_binary_pipe #(.N(4), .NCH(4), .MODE(0), .ERR_CNT_W(8)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(c_vld), .ready_o(c_rdyo), .val_i(c_val),
        .valid_o(c_ovld), .ready_i(1'b1), .idx_o(c_idx), .hit_o(c_hit), .err_o(c_err),
        .err_cnt_o(c_cnt), .clr_err_i(1'b0)
    );

    typedef struct packed {
        logic [2:0] idx;
        logic       hit;
        logic       err;
    } exp_t;

    exp_t sbq[$];
    int   mcnt   = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoding, highest set bit wins.
    function automatic exp_t enc_ref(input logic [7:0] v);
        exp_t r;
        int   ones;
        r    = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) if (v[i]) ones++;
        r.hit = (ones > 0);
        r.err = (ones > 1);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r.idx = 3'(i);
                break;
            end
        end
        return r;
    endfunction

    // Advance one clock on instance A, updating the scoreboard and checking outputs after the edge.
    task automatic a_cyc();
        bit   acc, cons;
        exp_t e;
        e    = enc_ref(a_val);
        acc  = rst_n && a_vld && (sbq.size() < 2);
        cons = rst_n && (sbq.size() > 0) && a_rdyi;
        if (!rst_n) begin
            sbq.delete();
            mcnt = 0;
        end else begin
            if (cons) void'(sbq.pop_front());
            if (acc) sbq.push_back(e);
            if (a_clr) mcnt = 0;
            else if (acc && e.err && mcnt < 3) mcnt++;
        end
        @(posedge clk);
        #1;
        chk("a_valid", 32'(a_ovld), 32'(sbq.size() > 0));
        chk("a_ready", 32'(a_rdyo), 32'(sbq.size() < 2));
        chk("a_cnt", 32'(a_cnt), 32'(mcnt));
        if (sbq.size() > 0) begin
            chk("a_idx", 32'(a_idx), 32'(sbq[0].idx));
            chk("a_hit", 32'(a_hit), 32'(sbq[0].hit));
            chk("a_err", 32'(a_err), 32'(sbq[0].err));
        end
    endtask

    logic [7:0] cnt_vals [6];
    int         cnt_exp  [5];

    initial begin
        cnt_vals = '{8'h03, 8'hC0, 8'hFF, 8'h81, 8'h18, 8'h06};
        cnt_exp  = '{1, 2, 3, 3, 3};
        rst_n = 1'b0;
        a_vld = 1'b0; a_val = '0; a_rdyi = 1'b1; a_clr = 1'b0;
        b_vld = 1'b0; b_val = '0;
        c_vld = 1'b0; c_val = '0;

        // Reset state
        a_cyc();
        a_cyc();
        chk("rst_idx", 32'(a_idx), 32'd0);
        chk("rst_hit", 32'(a_hit), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        rst_n = 1'b1;

        // Single channel one-hot / zero beats, one per cycle
        a_vld = 1'b1;
        a_val = 8'h01; a_cyc();
        chk("sc_idx0", 32'(a_idx), 32'd0);
        a_val = 8'h80; a_cyc();
        chk("sc_idx7", 32'(a_idx), 32'd7);
        a_val = 8'h00; a_cyc();
        chk("sc_hit0", 32'(a_hit), 32'd0);
        a_vld = 1'b0; a_cyc();

        // Multi-hot, highest wins
        a_vld = 1'b1; a_val = 8'h24; a_cyc();
        chk("mh_idx", 32'(a_idx), 32'd5);
        chk("mh_err", 32'(a_err), 32'd1);
        chk("mh_cnt", 32'(a_cnt), 32'd1);
        a_vld = 1'b0; a_cyc();

        // Backpressure: ready_i low three cycles with valid_i held
        a_vld = 1'b1; a_rdyi = 1'b0;
        a_val = 8'h02; a_cyc();
        a_val = 8'h04; a_cyc();
        chk("bp_ready_low", 32'(a_rdyo), 32'd0);
        a_val = 8'h08; a_cyc();
        a_rdyi = 1'b1; a_cyc();
        chk("bp_ready_back", 32'(a_rdyo), 32'd1);
        a_cyc();
        a_vld = 1'b0; a_cyc(); a_cyc(); a_cyc();

        // Random handshake traffic
        for (int k = 0; k < 60; k++) begin
            a_vld  = 1'($urandom_range(0, 1));
            a_rdyi = 1'($urandom_range(0, 3) != 0);
            a_val  = 8'($urandom);
            a_cyc();
        end
        a_vld = 1'b0; a_rdyi = 1'b1; a_cyc(); a_cyc(); a_cyc();

        // Saturating counter
        a_clr = 1'b1; a_cyc();
        a_clr = 1'b0; a_vld = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a_val = cnt_vals[k];
            a_cyc();
            chk("cnt_seq", 32'(a_cnt), 32'(cnt_exp[k]));
        end
        a_clr = 1'b1; a_val = cnt_vals[5]; a_cyc();
        chk("cnt_clr", 32'(a_cnt), 32'd0);
        a_clr = 1'b0; a_vld = 1'b0; a_cyc();

        // MODE 1 and four-channel instances
        b_vld = 1'b1; b_val = 8'h24;
        c_vld = 1'b1; c_val = 16'h8310;
        a_cyc();
        chk("b_valid", 32'(b_ovld), 32'd1);
        chk("b_idx", 32'(b_idx), 32'd2);
        chk("b_hit", 32'(b_hit), 32'd1);
        chk("b_err", 32'(b_err), 32'd1);
        chk("b_cnt", 32'(b_cnt), 32'd1);
        chk("c_valid", 32'(c_ovld), 32'd1);
        chk("c_idx", 32'(c_idx), 32'hD0);
        chk("c_hit", 32'(c_hit), 32'hE);
        chk("c_err", 32'(c_err), 32'h4);
        chk("c_cnt", 32'(c_cnt), 32'd1);
        b_vld = 1'b0; c_vld = 1'b0;
        a_cyc();
        chk("b_drained", 32'(b_ovld), 32'd0);
        chk("c_drained", 32'(c_ovld), 32'd0);
        chk("c_cnt_hold", 32'(c_cnt), 32'd1);

        // Reset while FULL
        a_vld = 1'b1; a_rdyi = 1'b0;
        a_val = 8'h05; a_cyc();
        a_val = 8'h09; a_cyc();
        chk("full_before_rst", 32'(a_rdyo), 32'd0);
        rst_n = 1'b0; a_cyc();
        chk("rst_valid", 32'(a_ovld), 32'd0);
        chk("rst_ready", 32'(a_rdyo), 32'd1);
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        rst_n = 1'b1; a_vld = 1'b0; a_rdyi = 1'b1;
        a_cyc(); a_cyc(); a_cyc();
        chk("no_stale", 32'(a_ovld), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
